difftest_commit_buffer: RTL and testbench

Parametrised successor to the single-snapshot GPR difftest hook. Captures a full architectural snapshot on every retired instruction: PC, next PC, instruction word, skip flag, and NREGS x XLEN GPRs. Holds snapshots in a DEPTH-entry FIFO and releases them to the simulator-side checker through a valid/ready handshake. This decouples core commit timing from difftest stepping. Sits beside the register file at the commit stage of npc.

---
 rtl/difftest_commit_buffer.sv | 130 +++++++++++++
 tb/tb_difftest_commit_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/difftest_commit_buffer.sv
// -----------------------------------------------------------------------------
// difftest_commit_buffer
//
// Captures an architectural snapshot (pc, npc, inst, skip, GPR file) for every
// retired instruction. The snapshots are held in a DEPTH-entry FIFO and handed
// to the simulator-side checker over a valid/ready handshake. This decouples
// core commit timing from difftest stepping.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   commit_valid/ready    push handshake; commit_ready = !full
//   commit_pc/npc/inst    retiring instruction PC, next PC and encoding
//   commit_skip           reference model must skip-and-copy this instruction
//   commit_rf             flattened GPRs, reg i at [i*XLEN +: XLEN]
//   out_valid/ready       pop handshake toward the checker
//   out_pc/npc/inst/skip  head snapshot fields, all zero while empty
//   out_rf                head GPR snapshot, all zero while empty
//   level                 current occupancy (0..DEPTH)
//   retired_cnt           snapshots accepted since reset (wraps silently)
//   overflow_err          sticky: a commit arrived while full and was dropped
// -----------------------------------------------------------------------------
module difftest_commit_buffer #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       commit_valid,
    output logic                       commit_ready,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic [XLEN-1:0]            commit_npc,
    input  logic [31:0]                commit_inst,
    input  logic                       commit_skip,
    input  logic [NREGS*XLEN-1:0]      commit_rf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_npc,
    output logic [31:0]                out_inst,
    output logic                       out_skip,
    output logic [NREGS*XLEN-1:0]      out_rf,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNTW-1:0]            retired_cnt,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [XLEN-1:0]       mem_pc   [DEPTH];
    logic [XLEN-1:0]       mem_npc  [DEPTH];
    logic [31:0]           mem_inst [DEPTH];
    logic                  mem_skip [DEPTH];
    logic [NREGS*XLEN-1:0] mem_rf   [DEPTH];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [NREGS*XLEN-1:0] rf_masked;

    // Flags derive only from registered occupancy, so no input reaches an output
    // combinationally; a pop in the same cycle does not open a slot for a push.
    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign commit_ready = !full;
    assign out_valid    = !empty;
    assign push         = commit_valid && commit_ready;
    assign pop          = out_valid && out_ready;

    // NOTE: every signal assigned in always_comb gets a full default first;
    // the later partial assignment then cannot infer a latch.
    always_comb begin
        rf_masked            = commit_rf;
        rf_masked[XLEN-1:0]  = '0;   // x0 is hardwired to zero
    end

    // NOTE: snapshot storage is deliberately not reset; only the pointers and
    // occupancy decide what is valid, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= commit_pc;
            mem_npc[wr_ptr]  <= commit_npc;
            mem_inst[wr_ptr] <= commit_inst;
            mem_skip[wr_ptr] <= commit_skip;
            mem_rf[wr_ptr]   <= rf_masked;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            retired_cnt  <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + PW'(1);
                retired_cnt <= retired_cnt + CNTW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (commit_valid && full) begin
                overflow_err <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Head entry read straight from registered storage; forced to zero when
    // empty so the checker never sees stale data.
    assign out_pc   = out_valid ? mem_pc[rd_ptr]   : '0;
    assign out_npc  = out_valid ? mem_npc[rd_ptr]  : '0;
    assign out_inst = out_valid ? mem_inst[rd_ptr] : '0;
    assign out_skip = out_valid ? mem_skip[rd_ptr] : 1'b0;
    assign out_rf   = out_valid ? mem_rf[rd_ptr]   : '0;

endmodule

// File: tb/tb_difftest_commit_buffer.sv
module tb_difftest_commit_buffer;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int DEPTH = 4;
    localparam int CNTW  = 64;
    localparam int RFW   = NREGS * XLEN;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             commit_valid;
    logic             commit_ready;
    logic [XLEN-1:0]  commit_pc;
    logic [XLEN-1:0]  commit_npc;
    logic [31:0]      commit_inst;
    logic             commit_skip;
    logic [RFW-1:0]   commit_rf;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_npc;
    logic [31:0]      out_inst;
    logic             out_skip;
    logic [RFW-1:0]   out_rf;
    logic [2:0]       level;
    logic [CNTW-1:0]  retired_cnt;
    logic             overflow_err;

    difftest_commit_buffer #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .DEPTH(DEPTH),
        .CNTW (CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_valid(commit_valid),
        .commit_ready(commit_ready),
        .commit_pc   (commit_pc),
        .commit_npc  (commit_npc),
        .commit_inst (commit_inst),
        .commit_skip (commit_skip),
        .commit_rf   (commit_rf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_npc     (out_npc),
        .out_inst    (out_inst),
        .out_skip    (out_skip),
        .out_rf      (out_rf),
        .level       (level),
        .retired_cnt (retired_cnt),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [31:0]     inst;
        logic            skip;
        logic [RFW-1:0]  rf;
    } snap_t;

    snap_t     sb[$];
    int        m_level;
    longint    m_cnt;
    logic      m_ovf;
    int        n_pass = 0;
    int        n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Drive one cycle of stimulus, check DUT state against the model mid-cycle,
    // then advance the model and the clock together.
    task automatic cycle(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic sk, input logic ordy);
        snap_t e;
        logic push_ok, pop_ok;
        e.pc   = pc;
        e.npc  = pc + 32'd4;
        e.inst = inst;
        e.skip = sk;
        for (int i = 0; i < NREGS; i++) e.rf[i*XLEN +: XLEN] = $urandom;
        e.rf[1*XLEN +: XLEN] = 32'd1;
        e.rf[0 +: XLEN]      = 32'hDEAD;

        commit_valid = cv;
        commit_pc    = e.pc;
        commit_npc   = e.npc;
        commit_inst  = e.inst;
        commit_skip  = e.skip;
        commit_rf    = e.rf;
        out_ready    = ordy;
        #4;

        check("level", 64'(level), 64'(m_level));
        check("commit_ready", 64'(commit_ready), 64'(m_level != DEPTH));
        check("out_valid", 64'(out_valid), 64'(m_level != 0));
        check("retired_cnt", retired_cnt, 64'(m_cnt));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        if (m_level != 0) begin
            check("out_pc", 64'(out_pc), 64'(sb[0].pc));
            check("out_npc", 64'(out_npc), 64'(sb[0].npc));
            check("out_inst", 64'(out_inst), 64'(sb[0].inst));
            check("out_skip", 64'(out_skip), 64'(sb[0].skip));
            check("out_rf0", 64'(out_rf[0 +: XLEN]), 64'(sb[0].rf[0 +: XLEN]));
            check("out_rf1", 64'(out_rf[XLEN +: XLEN]), 64'(sb[0].rf[XLEN +: XLEN]));
            check("out_rf5", 64'(out_rf[5*XLEN +: XLEN]), 64'(sb[0].rf[5*XLEN +: XLEN]));
            check("out_rf31", 64'(out_rf[31*XLEN +: XLEN]), 64'(sb[0].rf[31*XLEN +: XLEN]));
        end else begin
            check("empty_pc", 64'(out_pc), 64'd0);
            check("empty_skip", 64'(out_skip), 64'd0);
            check("empty_rf1", 64'(out_rf[XLEN +: XLEN]), 64'd0);
        end

        push_ok = cv && (m_level != DEPTH);
        pop_ok  = ordy && (m_level != 0);
        if (cv && !push_ok) m_ovf = 1'b1;
        if (pop_ok) void'(sb.pop_front());
        if (push_ok) begin
            e.rf[0 +: XLEN] = '0;
            sb.push_back(e);
            m_cnt++;
        end
        m_level = m_level + int'(push_ok) - int'(pop_ok);

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n        = 1'b0;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        sb.delete();
        m_level = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        commit_pc   = '0;
        commit_npc  = '0;
        commit_inst = '0;
        commit_skip = 1'b0;
        commit_rf   = '0;

        // Reset then idle
        do_reset(2);
        cycle(0, 0, 0, 0, 0);

        // Single commit, visible one cycle later, then popped
        cycle(1, 32'h8000_0000, 32'h0010_0093, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Fill to DEPTH, attempt a fifth commit, then drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'(i * 4), 32'h13 + 32'(i), 0, 0);
        cycle(1, 32'h10, 32'h99, 0, 0);          // dropped: overflow
        cycle(1, 32'h14, 32'h9a, 0, 1);          // full: pop but no push-through
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);                    // ready while empty: no effect

        // Steady simultaneous push/pop at level 2, pointers wrap
        cycle(1, 32'h1000, 32'h1, 0, 0);
        cycle(1, 32'h1004, 32'h2, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 32'h1008 + 32'(i * 4), 32'h3 + 32'(i), 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Reset mid-stream discards entries and clears the counter
        for (int i = 0; i < 3; i++) cycle(1, 32'h2000 + 32'(i * 4), 32'h7, 0, 0);
        cycle(0, 0, 0, 0, 0);
        do_reset(1);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 32'h100, 32'h0000_0073, 0, 0);
        cycle(0, 0, 0, 0, 1);

        // Skip entry held under backpressure
        cycle(1, 32'h200, 32'h3000_2073, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
